// File: rtl/ahb_lite_manager.sv
// ahb_lite_manager
// Single-transfer AHB-Lite initiator. Turns host commands into one AHB-Lite
// read or write at a time. It places write data on the correct byte lanes,
// extracts the addressed lane from read data, rejects misaligned or
// invalid-size commands locally, and handles the two-cycle ERROR response.
//
// Handshakes:
//   cmd: a command is taken on a rising edge where cmd_valid && cmd_ready.
//        cmd_ready is high only in IDLE, so at most one transfer is in flight.
//   rsp: rsp_valid is a one-cycle pulse with no backpressure. rsp_error and
//        rsp_rdata belong to that pulse and are held until the next response.
module ahb_lite_manager #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              n_rst,
   // host command side
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [1:0]        cmd_size,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   // host response side
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_error,
   output logic              busy,
   // AHB-Lite manager side
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [31:0]       hwdata,
   input  logic [31:0]       hrdata,
   input  logic              hready,
   input  logic              hresp,
   // FSM state for checkers: 0 IDLE, 1 ADDR, 2 DATA, 3 ERR2
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_ERR2 = 2'd3
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_t              r_state;
   logic                r_cmd_ready;
   logic                r_rsp_valid;
   logic [31:0]         r_rsp_rdata;
   logic                r_rsp_error;
   logic                r_busy;
   logic [ADDR_W-1:0]   r_haddr;
   logic [1:0]          r_htrans;
   logic                r_hwrite;
   logic [2:0]          r_hsize;
   logic [31:0]         r_hwdata;
   logic [31:0]         r_wdata;

   logic                w_accept;
   logic                w_reject;
   logic [31:0]         w_lane_wdata;
   logic [31:0]         w_lane_rdata;

   assign w_accept = cmd_valid && r_cmd_ready;

   // Local check: size 3 is invalid, and halves/words must be naturally aligned
   always_comb begin
      w_reject = 1'b0;
      case (cmd_size)
         2'd1:    w_reject = cmd_addr[0];
         2'd2:    w_reject = (cmd_addr[1:0] != 2'b00);
         2'd3:    w_reject = 1'b1;
         default: w_reject = 1'b0;
      endcase
   end

   // Replicate the right-justified write data across every lane of its size
   always_comb begin
      w_lane_wdata = r_wdata;
      case (r_hsize[1:0])
         2'd0:    w_lane_wdata = {4{r_wdata[7:0]}};
         2'd1:    w_lane_wdata = {2{r_wdata[15:0]}};
         default: w_lane_wdata = r_wdata;
      endcase
   end

   // Pick the addressed lane out of hrdata and right-justify it, zero-extended
   always_comb begin
      w_lane_rdata = hrdata;
      case (r_hsize[1:0])
         2'd0: begin
            case (r_haddr[1:0])
               2'd0:    w_lane_rdata = {24'h0, hrdata[7:0]};
               2'd1:    w_lane_rdata = {24'h0, hrdata[15:8]};
               2'd2:    w_lane_rdata = {24'h0, hrdata[23:16]};
               default: w_lane_rdata = {24'h0, hrdata[31:24]};
            endcase
         end
         2'd1:    w_lane_rdata = r_haddr[1] ? {16'h0, hrdata[31:16]}
                                            : {16'h0, hrdata[15:0]};
         default: w_lane_rdata = hrdata;
      endcase
   end

   // Transfer FSM; every output is a register updated here
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_error <= 1'b0;
         r_busy      <= 1'b0;
         r_haddr     <= '0;
         r_htrans    <= HTRANS_IDLE;
         r_hwrite    <= 1'b0;
         r_hsize     <= 3'b000;
         r_hwdata    <= 32'h0;
         r_wdata     <= 32'h0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (w_accept) begin
                  if (w_reject) begin
                     // no bus activity; answer with an error next cycle
                     r_rsp_valid <= 1'b1;
                     r_rsp_error <= 1'b1;
                     r_rsp_rdata <= 32'h0;
                  end else begin
                     r_state     <= ST_ADDR;
                     r_busy      <= 1'b1;
                     r_cmd_ready <= 1'b0;
                     r_htrans    <= HTRANS_NONSEQ;
                     r_haddr     <= cmd_addr;
                     r_hwrite    <= cmd_write;
                     r_hsize     <= {1'b0, cmd_size};
                     r_wdata     <= cmd_wdata;
                  end
               end
            end
            ST_ADDR: begin
               // address phase is held until the subordinate takes it
               if (hready) begin
                  r_state  <= ST_DATA;
                  r_htrans <= HTRANS_IDLE;
                  r_hwdata <= r_hwrite ? w_lane_wdata : 32'h0;
               end
            end
            ST_DATA: begin
               if (hready) begin
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_rsp_error <= hresp;
                  r_rsp_rdata <= (!r_hwrite && !hresp) ? w_lane_rdata : 32'h0;
               end else if (hresp) begin
                  // first cycle of a two-cycle ERROR response
                  r_state <= ST_ERR2;
               end
            end
            ST_ERR2: begin
               if (hready) begin
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_rsp_error <= 1'b1;
                  r_rsp_rdata <= 32'h0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_error = r_rsp_error;
   assign busy      = r_busy;
   assign haddr     = r_haddr;
   assign htrans    = r_htrans;
   assign hwrite    = r_hwrite;
   assign hsize     = r_hsize;
   assign hwdata    = r_hwdata;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_ahb_lite_manager.sv
// tb_ahb_lite_manager
// Directed bench for ahb_lite_manager. The stimulus thread issues commands,
// plays the subordinate cycle by cycle and checks bus timing; each command's
// response is queued as {rsp_error, rsp_rdata} and a separate monitor pops
// and compares whenever rsp_valid is seen.
module tb_ahb_lite_manager;

   logic        clk;
   logic        n_rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic        busy;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;
   logic [1:0]  dbg_state;

   int          n_checks;
   int          n_fail;
   logic [32:0] exp_q[$];

   ahb_lite_manager #(.ADDR_W(32)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_size  (cmd_size),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_error (rsp_error),
      .busy      (busy),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hwdata    (hwdata),
      .hrdata    (hrdata),
      .hready    (hready),
      .hresp     (hresp),
      .dbg_state (dbg_state)
   );

   // clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired, summary not reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one command; returns just after its accept edge
   task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wdata);
      check("cmd_ready_before_issue", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_size  = sz;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      tick();
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_size  = 2'd0;
      cmd_addr  = 32'h0;
      cmd_wdata = 32'h0;
   endtask

   // scoreboard monitor: every response must match the oldest expectation
   always @(negedge clk) begin
      logic [32:0] e;
      if (n_rst && rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid err=%0b rdata=0x%0h required none at %0t",
                     rsp_error, rsp_rdata, $time);
         end else begin
            e = exp_q.pop_front();
            check("rsp_error", rsp_error, e[32]);
            check("rsp_rdata", rsp_rdata, e[31:0]);
         end
      end
   end

   // directed stimulus with cycle-exact bus checks
   initial begin
      n_checks  = 0;
      n_fail    = 0;
      n_rst     = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_size  = 2'd0;
      cmd_addr  = 32'h0;
      cmd_wdata = 32'h0;
      hrdata    = 32'h0;
      hready    = 1'b1;
      hresp     = 1'b0;

      // reset state
      #2;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_htrans", htrans, 0);
      check("rst_haddr", haddr, 0);
      check("rst_busy", busy, 0);
      #20;
      n_rst = 1'b1;
      #1;
      check("cmd_ready_before_first_edge", cmd_ready, 0);
      tick();
      check("cmd_ready_after_release", cmd_ready, 1);

      // word write 0x10 <- 0xDEADBEEF, zero wait states
      exp_q.push_back({1'b0, 32'h0});
      issue(1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF);
      check("ww_htrans_n1", htrans, 2'b10);
      check("ww_haddr", haddr, 32'h10);
      check("ww_hwrite", hwrite, 1);
      check("ww_hsize", hsize, 3'b010);
      check("ww_cmd_ready_busy", {cmd_ready, busy}, 2'b01);
      check("ww_state_addr", dbg_state, 2'd1);
      tick();
      check("ww_htrans_n2", htrans, 2'b00);
      check("ww_hwdata", hwdata, 32'hDEAD_BEEF);
      tick();
      check("ww_rsp_valid_n3", rsp_valid, 1);
      check("ww_cmd_ready_n3", cmd_ready, 1);
      check("ww_busy_n3", busy, 0);
      tick();
      check("ww_rsp_pulse_one_cycle", rsp_valid, 0);

      // byte read 0x13, two data-phase wait states
      exp_q.push_back({1'b0, 32'h0000_00AA});
      issue(1'b0, 2'd0, 32'h0000_0013, 32'h0);
      check("br_htrans_n1", htrans, 2'b10);
      check("br_hsize", hsize, 3'b000);
      check("br_hwrite", hwrite, 0);
      tick();
      hready = 1'b0;
      check("br_htrans_n2", htrans, 2'b00);
      tick();
      check("br_haddr_wait1", haddr, 32'h13);
      check("br_rsp_valid_wait1", rsp_valid, 0);
      check("br_busy_wait1", busy, 1);
      tick();
      check("br_haddr_wait2", haddr, 32'h13);
      check("br_hsize_wait2", hsize, 3'b000);
      hready = 1'b1;
      hrdata = 32'hAABB_CCDD;
      tick();
      check("br_rsp_valid_n5", rsp_valid, 1);
      hrdata = 32'h0;
      tick();

      // half write 0x22 <- 0x1234
      exp_q.push_back({1'b0, 32'h0});
      issue(1'b1, 2'd1, 32'h0000_0022, 32'h0000_1234);
      check("hw_hsize", hsize, 3'b001);
      tick();
      check("hw_hwdata", hwdata, 32'h1234_1234);
      tick();
      check("hw_rsp_valid", rsp_valid, 1);
      tick();

      // half read 0x22 with one address-phase wait state
      exp_q.push_back({1'b0, 32'h0000_5566});
      hready = 1'b0;
      issue(1'b0, 2'd1, 32'h0000_0022, 32'h0);
      check("hr_htrans_n1", htrans, 2'b10);
      tick();
      check("hr_htrans_held", htrans, 2'b10);
      check("hr_haddr_held", haddr, 32'h22);
      hready = 1'b1;
      tick();
      check("hr_htrans_data", htrans, 2'b00);
      hrdata = 32'h5566_7788;
      tick();
      check("hr_rsp_valid", rsp_valid, 1);
      hrdata = 32'h0;
      tick();

      // local reject: misaligned half, then size 3
      exp_q.push_back({1'b1, 32'h0});
      issue(1'b1, 2'd1, 32'h0000_0001, 32'h0000_FFFF);
      check("rj1_rsp_valid_n1", rsp_valid, 1);
      check("rj1_htrans", htrans, 2'b00);
      check("rj1_cmd_ready", cmd_ready, 1);
      check("rj1_busy", busy, 0);
      tick();
      check("rj1_htrans_after", htrans, 2'b00);
      check("rj1_rsp_pulse", rsp_valid, 0);
      exp_q.push_back({1'b1, 32'h0});
      issue(1'b0, 2'd3, 32'h0000_0000, 32'h0);
      check("rj2_rsp_valid_n1", rsp_valid, 1);
      check("rj2_htrans", htrans, 2'b00);
      check("rj2_cmd_ready", cmd_ready, 1);
      tick();
      check("rj2_htrans_after", htrans, 2'b00);

      // two-cycle ERROR response on a word read
      exp_q.push_back({1'b1, 32'h0});
      issue(1'b0, 2'd2, 32'h0000_0080, 32'h0);
      check("er_htrans_n1", htrans, 2'b10);
      tick();
      hresp  = 1'b1;
      hready = 1'b0;
      hrdata = 32'hFFFF_FFFF;
      check("er_htrans_err1", htrans, 2'b00);
      tick();
      check("er_htrans_err2", htrans, 2'b00);
      check("er_state_err2", dbg_state, 2'd3);
      check("er_rsp_valid_err2", rsp_valid, 0);
      hready = 1'b1;
      tick();
      check("er_rsp_valid", rsp_valid, 1);
      check("er_htrans_rsp", htrans, 2'b00);
      hresp  = 1'b0;
      hrdata = 32'h0;
      tick();

      // reset in the middle of a wait-stated data phase
      issue(1'b1, 2'd2, 32'h0000_0044, 32'h1122_3344);
      tick();
      hready = 1'b0;
      check("rs_hwdata_before", hwdata, 32'h1122_3344);
      tick();
      #3;
      n_rst = 1'b0;
      #1;
      check("rs_outputs_async",
            {cmd_ready, rsp_valid, rsp_error, busy, htrans, hwrite, hsize},
            {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000});
      check("rs_haddr", haddr, 32'h0);
      check("rs_hwdata", hwdata, 32'h0);
      check("rs_rsp_rdata", rsp_rdata, 32'h0);
      tick();
      tick();
      #3;
      n_rst  = 1'b1;
      hready = 1'b1;
      #1;
      check("rs_cmd_ready_pre_edge", cmd_ready, 0);
      tick();
      check("rs_cmd_ready_one_edge", cmd_ready, 1);

      // back-to-back: second command accepted in the first one's rsp_valid cycle
      exp_q.push_back({1'b0, 32'h0});
      issue(1'b1, 2'd2, 32'h0000_0050, 32'h0000_0001);
      tick();
      tick();
      check("bb_rsp_valid_a", rsp_valid, 1);
      check("bb_cmd_ready_a", cmd_ready, 1);
      exp_q.push_back({1'b0, 32'h0000_0077});
      issue(1'b0, 2'd0, 32'h0000_0051, 32'h0);
      check("bb_htrans_b", htrans, 2'b10);
      check("bb_haddr_b", haddr, 32'h51);
      check("bb_rsp_valid_gap", rsp_valid, 0);
      tick();
      hrdata = 32'h0000_7700;
      tick();
      check("bb_rsp_valid_b", rsp_valid, 1);
      hrdata = 32'h0;
      tick();

      repeat (3) tick();
      check("exp_q_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
